// File: rtl/bsg_dram_cmd_scheduler.sv
// DRAM command scheduler: issues a mode-register set after reset, then arbitrates
// read/write requests round-robin and issues ACT (on open-row miss) followed by READ/WRITE.
module bsg_dram_cmd_scheduler #(
   parameter logic [2:0] burst_len_code_p = 3'b011,
   parameter logic [2:0] cas_latency_p    = 3'b011
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        rd_v_i,
   input  logic [1:0]  rd_bank_i,
   input  logic [13:0] rd_row_i,
   input  logic [10:0] rd_col_i,
   output logic        rd_ready_o,
   input  logic        wr_v_i,
   input  logic [1:0]  wr_bank_i,
   input  logic [13:0] wr_row_i,
   input  logic [10:0] wr_col_i,
   output logic        wr_ready_o,
   output logic        cmd_v_o,
   output logic [25:0] cmd_data_o,
   input  logic        cmd_ready_i,
   output logic        init_done_o
);

   typedef enum logic [1:0] {MRS, IDLE, ACT, RW} state_e;

   state_e      state_q, state_d;
   logic        init_done_q, init_done_d;
   logic        last_grant_wr_q, last_grant_wr_d;
   logic        grant_wr_q, grant_wr_d;
   logic [1:0]  req_bank_q, req_bank_d;
   logic [13:0] req_row_q, req_row_d;
   logic [10:0] req_col_q, req_col_d;
   logic        open_v_q, open_v_d;
   logic [1:0]  open_bank_q, open_bank_d;
   logic [13:0] open_row_q, open_row_d;

   logic        xfer;
   logic        req_any;
   logic        pick_wr;
   logic        hit;
   logic [1:0]  sel_bank;
   logic [13:0] sel_row;
   logic [10:0] sel_col;

   logic [2:0]  cmd_bank;
   logic [15:0] cmd_addr;
   logic [3:0]  cmd_op;
   logic        cmd_odt;

   // Reset gates the handshake combinationally so nothing is offered while held in reset.
   assign cmd_v_o     = ~reset_i & (state_q != IDLE);
   assign xfer        = cmd_v_o & cmd_ready_i;
   assign rd_ready_o  = xfer & (state_q == RW) & ~grant_wr_q;
   assign wr_ready_o  = xfer & (state_q == RW) & grant_wr_q;
   assign init_done_o = init_done_q;

   always_comb begin
      req_any  = init_done_q & (rd_v_i | wr_v_i);
      pick_wr  = wr_v_i & (~rd_v_i | ~last_grant_wr_q);
      sel_bank = pick_wr ? wr_bank_i : rd_bank_i;
      sel_row  = pick_wr ? wr_row_i  : rd_row_i;
      sel_col  = pick_wr ? wr_col_i  : rd_col_i;
      hit      = open_v_q & (open_bank_q == sel_bank) & (open_row_q == sel_row);
   end

   always_comb begin
      state_d         = state_q;
      init_done_d     = init_done_q;
      last_grant_wr_d = last_grant_wr_q;
      grant_wr_d      = grant_wr_q;
      req_bank_d      = req_bank_q;
      req_row_d       = req_row_q;
      req_col_d       = req_col_q;
      open_v_d        = open_v_q;
      open_bank_d     = open_bank_q;
      open_row_d      = open_row_q;
      case (state_q)
         MRS: begin
            if (xfer) begin
               state_d     = IDLE;
               init_done_d = 1'b1;
            end
         end
         IDLE: begin
            if (req_any) begin
               grant_wr_d = pick_wr;
               req_bank_d = sel_bank;
               req_row_d  = sel_row;
               req_col_d  = sel_col;
               state_d    = hit ? RW : ACT;
            end
         end
         ACT: begin
            if (xfer) begin
               state_d     = RW;
               open_v_d    = 1'b1;
               open_bank_d = req_bank_q;
               open_row_d  = req_row_q;
            end
         end
         RW: begin
            if (xfer) begin
               state_d         = IDLE;
               last_grant_wr_d = grant_wr_q;
            end
         end
         default: state_d = MRS;
      endcase
   end

   // Command word is built only from state and captured request registers, so it is stall-stable.
   always_comb begin
      cmd_bank = 3'b000;
      cmd_addr = 16'h0000;
      cmd_op   = 4'b1111;
      cmd_odt  = 1'b0;
      case (state_q)
         MRS: begin
            cmd_op   = 4'b0000;
            cmd_addr = {9'b0, cas_latency_p, 1'b0, burst_len_code_p};
         end
         ACT: begin
            cmd_op   = 4'b0011;
            cmd_bank = {1'b0, req_bank_q};
            cmd_addr = {2'b0, req_row_q};
         end
         RW: begin
            cmd_op   = grant_wr_q ? 4'b0100 : 4'b0101;
            cmd_bank = {1'b0, req_bank_q};
            cmd_addr = {4'b0, req_col_q[10], 1'b0, req_col_q[9:0]};
            cmd_odt  = grant_wr_q;
         end
         default: cmd_op = 4'b1111;
      endcase
      cmd_data_o = {cmd_bank, cmd_addr, 1'b1, cmd_op, 1'b1, cmd_odt};
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q         <= MRS;
         init_done_q     <= 1'b0;
         last_grant_wr_q <= 1'b1;
         grant_wr_q      <= 1'b0;
         req_bank_q      <= 2'b00;
         req_row_q       <= 14'h0;
         req_col_q       <= 11'h0;
         open_v_q        <= 1'b0;
         open_bank_q     <= 2'b00;
         open_row_q      <= 14'h0;
      end else begin
         state_q         <= state_d;
         init_done_q     <= init_done_d;
         last_grant_wr_q <= last_grant_wr_d;
         grant_wr_q      <= grant_wr_d;
         req_bank_q      <= req_bank_d;
         req_row_q       <= req_row_d;
         req_col_q       <= req_col_d;
         open_v_q        <= open_v_d;
         open_bank_q     <= open_bank_d;
         open_row_q      <= open_row_d;
      end
   end

endmodule

// File: tb/tb_bsg_dram_cmd_scheduler.sv
// Self-checking bench for bsg_dram_cmd_scheduler: directed steps with a scoreboard of
// expected commands popped by a monitor on every command transfer.
module tb_bsg_dram_cmd_scheduler;

   localparam logic [3:0] OP_MRS = 4'b0000;
   localparam logic [3:0] OP_ACT = 4'b0011;
   localparam logic [3:0] OP_RD  = 4'b0101;
   localparam logic [3:0] OP_WR  = 4'b0100;

   typedef struct {
      logic [25:0] data;
      logic        rdRdy;
      logic        wrRdy;
   } expT;

   logic        clock;
   logic        reset;
   logic        rdV, wrV, cmdReady;
   logic [1:0]  rdBank, wrBank;
   logic [13:0] rdRow, wrRow;
   logic [10:0] rdCol, wrCol;
   logic        rdReady, wrReady, cmdV, initDone;
   logic [25:0] cmdData;

   expT         expQ[$];
   expT         popped;
   int          errors = 0;
   int          checks = 0;
   int          lat;
   logic        monOn = 1'b0;
   logic [25:0] mrsCmd;

   bsg_dram_cmd_scheduler dut (
      .clk_i       (clock),
      .reset_i     (reset),
      .rd_v_i      (rdV),
      .rd_bank_i   (rdBank),
      .rd_row_i    (rdRow),
      .rd_col_i    (rdCol),
      .rd_ready_o  (rdReady),
      .wr_v_i      (wrV),
      .wr_bank_i   (wrBank),
      .wr_row_i    (wrRow),
      .wr_col_i    (wrCol),
      .wr_ready_o  (wrReady),
      .cmd_v_o     (cmdV),
      .cmd_data_o  (cmdData),
      .cmd_ready_i (cmdReady),
      .init_done_o (initDone)
   );

   // Free-running clock, 10 time units per cycle.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [25:0] mkCmd(input logic [2:0] bank, input logic [15:0] addr,
                                         input logic [3:0] op, input logic odt);
      return {bank, addr, 1'b1, op, 1'b1, odt};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   task automatic applyStimulus(input logic rv, input logic [1:0] rb, input logic [13:0] rr, input logic [10:0] rc,
                                input logic wv, input logic [1:0] wb, input logic [13:0] wr, input logic [10:0] wc,
                                input logic cr);
      rdV = rv; rdBank = rb; rdRow = rr; rdCol = rc;
      wrV = wv; wrBank = wb; wrRow = wr; wrCol = wc;
      cmdReady = cr;
   endtask

   task automatic pushExp(input logic [25:0] d, input logic r, input logic w);
      expT e;
      e.data = d; e.rdRdy = r; e.wrRdy = w;
      expQ.push_back(e);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Returns the number of cycles from the current cycle to the ready pulse, or -1 on timeout.
   task automatic waitReady(input logic wantWr, output int latency);
      latency = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if ((wantWr ? wrReady : rdReady) === 1'b1) begin
            latency = k;
            break;
         end
         tick();
      end
   endtask

   // Scoreboard monitor: every transfer must match the head of the queue; ready only on transfers.
   always @(negedge clock) begin
      if (monOn) begin
         if (cmdV === 1'b1 && cmdReady === 1'b1) begin
            if (expQ.size() == 0) begin
               checkOutput("xferQueued", 32'(expQ.size()), 32'd1);
            end else begin
               popped = expQ.pop_front();
               checkOutput("cmdData", 32'(cmdData), 32'(popped.data));
               checkOutput("readyAtXfer", 32'({rdReady, wrReady}), 32'({popped.rdRdy, popped.wrRdy}));
            end
         end else begin
            checkOutput("readyNoXfer", 32'({rdReady, wrReady}), 32'd0);
         end
      end
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      mrsCmd = mkCmd(3'b000, 16'h0033, OP_MRS, 1'b0);
      reset  = 1'b1;
      applyStimulus(0, 2'd0, 14'h0, 11'h0, 0, 2'd0, 14'h0, 11'h0, 1);
      repeat (3) @(posedge clock);
      #1;
      monOn = 1'b1;

      // Held in reset: nothing offered, not initialised.
      @(negedge clock);
      checkOutput("resetCmdV", 32'(cmdV), 32'd0);
      checkOutput("resetRdReady", 32'(rdReady), 32'd0);
      checkOutput("resetWrReady", 32'(wrReady), 32'd0);
      checkOutput("resetInitDone", 32'(initDone), 32'd0);

      // Release: MRS on the first cycle, init_done the cycle after.
      tick();
      pushExp(mrsCmd, 0, 0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("mrsFirstCycleV", 32'(cmdV), 32'd1);
      checkOutput("mrsInitDoneLow", 32'(initDone), 32'd0);
      tick();
      @(negedge clock);
      checkOutput("initDoneHigh", 32'(initDone), 32'd1);
      checkOutput("idleCmdV", 32'(cmdV), 32'd0);

      // Single read, no open row: ACT then READ.
      tick();
      pushExp(mkCmd(3'b010, 16'h1234, OP_ACT, 1'b0), 0, 0);
      pushExp(mkCmd(3'b010, 16'h08FF, OP_RD, 1'b0), 1, 0);
      applyStimulus(1, 2'd2, 14'h1234, 11'h4FF, 0, 2'd0, 14'h0, 11'h0, 1);
      waitReady(1'b0, lat);
      checkOutput("missLatency", 32'(lat), 32'd2);
      tick();
      applyStimulus(0, 2'd0, 14'h0, 11'h0, 0, 2'd0, 14'h0, 11'h0, 1);

      // Second read to the same row: READ only, one cycle after request.
      tick();
      pushExp(mkCmd(3'b010, 16'h0123, OP_RD, 1'b0), 1, 0);
      applyStimulus(1, 2'd2, 14'h1234, 11'h123, 0, 2'd0, 14'h0, 11'h0, 1);
      waitReady(1'b0, lat);
      checkOutput("hitLatency", 32'(lat), 32'd1);
      tick();
      applyStimulus(0, 2'd0, 14'h0, 11'h0, 0, 2'd0, 14'h0, 11'h0, 1);

      // Single write to another bank: ACT then WRITE with odt.
      tick();
      pushExp(mkCmd(3'b001, 16'h0AAA, OP_ACT, 1'b0), 0, 0);
      pushExp(mkCmd(3'b001, 16'h0007, OP_WR, 1'b1), 0, 1);
      applyStimulus(0, 2'd0, 14'h0, 11'h0, 1, 2'd1, 14'h0AAA, 11'h007, 1);
      waitReady(1'b1, lat);
      checkOutput("writeMissLatency", 32'(lat), 32'd2);
      tick();
      applyStimulus(0, 2'd0, 14'h0, 11'h0, 0, 2'd0, 14'h0, 11'h0, 1);

      // Both held: READ, WRITE, READ, each behind an ACT.
      tick();
      pushExp(mkCmd(3'b010, 16'h1234, OP_ACT, 1'b0), 0, 0);
      pushExp(mkCmd(3'b010, 16'h08FF, OP_RD, 1'b0), 1, 0);
      pushExp(mkCmd(3'b001, 16'h0AAA, OP_ACT, 1'b0), 0, 0);
      pushExp(mkCmd(3'b001, 16'h0007, OP_WR, 1'b1), 0, 1);
      pushExp(mkCmd(3'b010, 16'h1234, OP_ACT, 1'b0), 0, 0);
      pushExp(mkCmd(3'b010, 16'h08FF, OP_RD, 1'b0), 1, 0);
      applyStimulus(1, 2'd2, 14'h1234, 11'h4FF, 1, 2'd1, 14'h0AAA, 11'h007, 1);
      waitReady(1'b0, lat);
      checkOutput("rrRead1Latency", 32'(lat), 32'd2);
      waitReady(1'b1, lat);
      checkOutput("rrWriteLatency", 32'(lat), 32'd2);
      waitReady(1'b0, lat);
      checkOutput("rrRead2Latency", 32'(lat), 32'd2);
      tick();
      applyStimulus(0, 2'd0, 14'h0, 11'h0, 0, 2'd0, 14'h0, 11'h0, 1);

      // Stall during ACT for 5 cycles; request fields scrambled mid-stall.
      tick();
      pushExp(mkCmd(3'b011, 16'h0055, OP_ACT, 1'b0), 0, 0);
      pushExp(mkCmd(3'b011, 16'h0010, OP_RD, 1'b0), 1, 0);
      applyStimulus(1, 2'd3, 14'h0055, 11'h010, 0, 2'd0, 14'h0, 11'h0, 0);
      @(negedge clock);
      checkOutput("stallIdleV", 32'(cmdV), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 2) applyStimulus(1, 2'd0, 14'h3FFF, 11'h7FF, 0, 2'd0, 14'h0, 11'h0, 0);
         @(negedge clock);
         checkOutput("stallActV", 32'(cmdV), 32'd1);
         checkOutput("stallActData", 32'(cmdData), 32'(mkCmd(3'b011, 16'h0055, OP_ACT, 1'b0)));
      end
      tick();
      cmdReady = 1'b1;
      waitReady(1'b0, lat);
      checkOutput("postStallLatency", 32'(lat), 32'd1);
      tick();
      applyStimulus(0, 2'd0, 14'h0, 11'h0, 0, 2'd0, 14'h0, 11'h0, 1);

      // Reset during a stalled READ: no ready, MRS reissued, row tracker cleared.
      tick();
      applyStimulus(1, 2'd3, 14'h0055, 11'h020, 0, 2'd0, 14'h0, 11'h0, 0);
      @(negedge clock);
      tick();
      @(negedge clock);
      checkOutput("rwStallV", 32'(cmdV), 32'd1);
      checkOutput("rwStallData", 32'(cmdData), 32'(mkCmd(3'b011, 16'h0020, OP_RD, 1'b0)));
      tick();
      reset = 1'b1;
      tick();
      @(negedge clock);
      checkOutput("midResetCmdV", 32'(cmdV), 32'd0);
      checkOutput("midResetInitDone", 32'(initDone), 32'd0);
      checkOutput("midResetRdReady", 32'(rdReady), 32'd0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         checkOutput("holdMrsV", 32'(cmdV), 32'd1);
         checkOutput("holdMrsData", 32'(cmdData), 32'(mrsCmd));
         checkOutput("holdMrsInitDone", 32'(initDone), 32'd0);
         tick();
      end
      pushExp(mrsCmd, 0, 0);
      pushExp(mkCmd(3'b011, 16'h0055, OP_ACT, 1'b0), 0, 0);
      pushExp(mkCmd(3'b011, 16'h0020, OP_RD, 1'b0), 1, 0);
      cmdReady = 1'b1;
      waitReady(1'b0, lat);
      checkOutput("afterResetLatency", 32'(lat), 32'd3);
      tick();
      applyStimulus(0, 2'd0, 14'h0, 11'h0, 0, 2'd0, 14'h0, 11'h0, 1);

      repeat (3) tick();
      checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bsg_dram_cmd_scheduler.md
BSG_DRAM_CMD_SCHEDULER -- requirements
Module: bsg_dram_cmd_scheduler

Interface
REQ-001 The block SHALL have parameter burst_len_code_p, default 3'b011; it is the mode-register burst-length code (001=2, 010=4, 011=8, 100=16).
REQ-002 The block SHALL have parameter cas_latency_p, default 3'b011; it is the mode-register CAS latency code.
REQ-003 The block SHALL have port clk_i, input, 1 bit; the single clock.
REQ-004 The block SHALL have port reset_i, input, 1 bit; synchronous, active-high reset.
REQ-005 The block SHALL have read-request ports rd_v_i (1), rd_bank_i (2), rd_row_i (14), rd_col_i (11), all inputs, and rd_ready_o (1), output.
REQ-006 The block SHALL have write-request ports wr_v_i (1), wr_bank_i (2), wr_row_i (14), wr_col_i (11), all inputs, and wr_ready_o (1), output.
REQ-007 The block SHALL have cmd_v_o, output, 1 bit; command valid.
REQ-008 The block SHALL have cmd_data_o, output, 26 bits; packed {bank[2:0], address[15:0], cke, cs_n, ras_n, cas_n, we_n, reset_n, odt}.
REQ-009 The block SHALL have cmd_ready_i, input, 1 bit; downstream command-FIFO ready.
REQ-010 The block SHALL have init_done_o, output, 1 bit; asserted once the mode-register command has been accepted.

Function
REQ-011 A command transfer SHALL occur on any cycle with cmd_v_o and cmd_ready_i both high.
- cmd_data_o SHALL stay stable while cmd_v_o is high and cmd_ready_i is low.
REQ-012 FSM states SHALL be: MRS, IDLE, ACT, RW.
- Reset SHALL enter MRS.
- MRS -> IDLE on transfer.
- IDLE -> ACT when a request is granted and its bank/row misses the open row; otherwise IDLE -> RW.
- ACT -> RW on transfer.
- RW -> IDLE on transfer.
REQ-013 The MRS command SHALL use cs_n/ras_n/cas_n/we_n=0000, bank=0, address={9'b0, cas_latency_p, 1'b0, burst_len_code_p}.
REQ-014 The ACT command SHALL use cs_n/ras_n/cas_n/we_n=0011, bank={1'b0, req_bank}, address={2'b0, req_row}.
REQ-015 The READ command SHALL use cs_n/ras_n/cas_n/we_n=0101; the WRITE command SHALL use 0100.
- For both, address={4'b0, col[10], 1'b0, col[9:0]}, with address[10] (auto-precharge) always 0.
REQ-016 cke and reset_n SHALL be 1 in every command; odt SHALL be 1 only in WRITE commands.
REQ-017 Arbitration in IDLE SHALL be round-robin on a last_grant register.
- If only one requester is valid, it wins.
- If both are valid, the one not last granted wins.
- last_grant SHALL update when the RW transfer completes.
REQ-018 The grant (rd or wr) and the request fields SHALL be captured into registers at the IDLE decision.
- Later changes on the rd_*/wr_* inputs SHALL NOT affect the in-flight sequence.
REQ-019 rd_ready_o/wr_ready_o SHALL pulse high for exactly one cycle, combinationally, on the cycle of that requester's RW transfer.
- Requesters SHALL hold v and fields until ready.
- The ungranted requester's ready SHALL stay 0.
REQ-020 Open-row tracker: registers open_v, open_bank[1:0], open_row[13:0].
- An ACT transfer SHALL set open_v=1 and load bank/row.
- A hit SHALL require open_v and equal bank and row.
- A request to a different bank or row SHALL issue a new ACT, replacing the tracked entry.
REQ-021 cmd_v_o SHALL be 1 in MRS, ACT and RW, and 0 in IDLE.
- Minimum latency, request valid to RW transfer: 1 cycle on a hit, 2 cycles on a miss, with cmd_ready_i high.
REQ-022 No request SHALL be granted before init_done_o=1; rd_ready_o/wr_ready_o SHALL be 0 until then.

Reset
REQ-023 While reset_i is high, the following SHALL hold at the next clock edge and throughout reset:
- cmd_v_o=0, rd_ready_o=0, wr_ready_o=0, init_done_o=0.
- open_v=0, last_grant=wr (so read wins the first tie), state=MRS.
REQ-024 Reset asserted mid-sequence SHALL abandon the sequence without issuing its ready pulse.
- After deassertion, MRS SHALL reissue on the first cycle.

Verification
REQ-025 Reset release with cmd_ready_i=1 SHALL produce, on the first cycle, cmd_data_o with bank=0, address=16'h0033, cs/ras/cas/we=0000, cke=1, reset_n=1, odt=0; init_done_o SHALL be 1 the following cycle.
REQ-026 A single read (bank 2, row 0x1234, col 0x4FF), from an idle state with no open row, SHALL produce:
- ACT: bank=3'b010, address=16'h1234.
- READ: address=16'h08FF, opcode 0101, with rd_ready_o high on the same cycle.
REQ-027 A second read to the same bank and row SHALL produce only a READ command (no ACT), transferred one cycle after rd_v_i rises.
REQ-028 With rd_v_i and wr_v_i both held continuously to different rows, commands SHALL alternate READ, then WRITE, then READ, each preceded by an ACT; WRITE commands SHALL carry odt=1.
REQ-029 With cmd_ready_i held low for 5 cycles during ACT, cmd_data_o SHALL stay stable and the state SHALL not advance; the request fields SHALL change mid-stall with no effect on the output.
REQ-030 Reset pulsed during a stalled RW SHALL produce no ready pulse; the first transfer after release SHALL be MRS, and open_v SHALL be 0 so the next request issues an ACT.
